// File: rtl/sar_search_pkg.sv
// Shared definitions for the successive-approximation search controller and
// the magnitude comparator it drives.
package sar_search_pkg;

   localparam logic [1:0] CMP_INV = 2'b00;
   localparam logic [1:0] CMP_EQ  = 2'b01;
   localparam logic [1:0] CMP_GT  = 2'b10;
   localparam logic [1:0] CMP_LT  = 2'b11;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      TRIAL   = 2'd1,
      CONFIRM = 2'd2
   } state_e;

endpackage

// File: rtl/sar_search.sv
// Binary-search controller: resolves the comparator's target operand one bit
// per cycle, MSB first, then confirms the final guess with an equality check.
module sar_search
   import sar_search_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [1:0]       cmp_code,
   output logic [WIDTH-1:0] guess,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             found,
   output logic             err
);

   localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   state_e           state;
   logic [IDX_W-1:0] idx;
   logic [WIDTH-1:0] bit_hi;
   logic [WIDTH-1:0] bit_lo;
   logic [WIDTH-1:0] guess_keep;
   logic [WIDTH-1:0] guess_drop;

   // bit_lo is empty at idx 0, so the same masks serve the last trial bit.
   always_comb begin
      bit_hi     = {{(WIDTH-1){1'b0}}, 1'b1} << idx;
      bit_lo     = bit_hi >> 1;
      guess_keep = guess | bit_lo;
      guess_drop = (guess & ~bit_hi) | bit_lo;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         idx    <= '0;
         guess  <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
         result <= '0;
         found  <= 1'b0;
         err    <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  guess  <= {1'b1, {(WIDTH-1){1'b0}}};
                  idx    <= IDX_W'(WIDTH-1);
                  result <= '0;
                  found  <= 1'b0;
                  err    <= 1'b0;
                  busy   <= 1'b1;
                  state  <= TRIAL;
               end
            end
            TRIAL: begin
               case (cmp_code)
                  CMP_EQ: begin
                     result <= guess;
                     found  <= 1'b1;
                     done   <= 1'b1;
                     busy   <= 1'b0;
                     state  <= IDLE;
                  end
                  CMP_GT, CMP_LT: begin
                     guess <= (cmp_code == CMP_GT) ? guess_keep : guess_drop;
                     if (idx != '0) begin
                        idx <= idx - 1'b1;
                     end else begin
                        state <= CONFIRM;
                     end
                  end
                  default: begin
                     result <= guess;
                     found  <= 1'b0;
                     err    <= 1'b1;
                     done   <= 1'b1;
                     busy   <= 1'b0;
                     state  <= IDLE;
                  end
               endcase
            end
            CONFIRM: begin
               // A non-equal code here means the target moved during the search.
               result <= guess;
               found  <= (cmp_code == CMP_EQ);
               err    <= (cmp_code == CMP_INV);
               done   <= 1'b1;
               busy   <= 1'b0;
               state  <= IDLE;
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/sar_search.md
# sar_search

Successive-approximation search controller that drives the guess operand of the 4-bit magnitude comparator and reads back its 2-bit compare code. It determines the unknown operand on the comparator's A input one bit per cycle, MSB first, and then confirms the final value with an equality check. It sits on the initiator side of the comparator interface: the comparator's A is the target, its B is driven by `guess`, and its C feeds `cmp_code`.

## Interface
- WIDTH, 4, operand width; must match the comparator.
- clk  in  1  sole clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request a search; accepted only in IDLE.
- cmp_code  in  2  comparator code for target vs `guess`: 01 equal, 10 target>guess, 11 target<guess, 00 invalid.
- guess  out  WIDTH  registered trial value driven to comparator B.
- busy  out  1  high from the cycle after start is accepted until the search ends.
- done  out  1  one-cycle pulse at search end.
- result  out  WIDTH  found value; valid when `done`; held until the next accepted start.
- found  out  1  final value confirmed equal; held like `result`.
- err  out  1  invalid code (00) seen; held like `result`.

## Operation
- States: IDLE, TRIAL, CONFIRM. Registers: guess, bit index idx, and the outputs.
- IDLE + start: guess <= 1<<(WIDTH-1); idx <= WIDTH-1; clear result, found, err; go TRIAL. start in TRIAL/CONFIRM is ignored.
- TRIAL samples cmp_code each cycle:
  - 01: result <= guess, found <= 1, done, go IDLE (early exit).
  - 10, idx>0: keep bit idx, set bit idx-1, idx--.
  - 11, idx>0: clear bit idx, set bit idx-1, idx--.
  - 10, idx==0: keep guess, go CONFIRM.
  - 11, idx==0: clear bit 0, go CONFIRM.
  - 00: err <= 1, result <= guess, found <= 0, done, go IDLE.
- CONFIRM samples cmp_code once: 01 gives found=1. 10 or 11 gives found=0, meaning the target changed mid-search. 00 gives err=1. In every case result <= guess, done, go IDLE.
- guess holds its last value in IDLE.
- Arithmetic: bit set and clear only; no adders. guess never exceeds 2^WIDTH-1.

## Timing
- Reset values: guess 0, busy 0, done 0, result 0, found 0, err 0, state IDLE.
- rst mid-search aborts immediately to reset values. No done is issued for the aborted search.
- The comparator is combinational on `guess`. Each sampling edge sees the code for the guess registered at the previous edge.
- Edge numbering: start is accepted at edge E0. cmp_code is sampled at E1..EN.
- Latency: done is high in the cycle after the final sampling edge.
  - Minimum: 1 sampling edge (target = 1<<(WIDTH-1)).
  - Maximum: WIDTH+1 sampling edges (exhausting all bits, then CONFIRM).
- done and busy: busy drops in the same cycle that done is high. The next start is accepted that cycle or later.
- Simultaneous rst and start: rst wins.

## Structure
- Shared package holds:
  - Compare-code constants: CMP_INV=2'b00, CMP_EQ=2'b01, CMP_GT=2'b10, CMP_LT=2'b11. These are also used by the comparator bench.
  - State enum {IDLE, TRIAL, CONFIRM}.
- Single module, no sub-module. The comparator is instantiated alongside `sar_search` at the next level up, never inside it.

## Test plan
- Target A=5, pulse start: guess sequence 8,4,6,5. done after E4; result=5, found=1, err=0.
- Target A=8: equal at E1. done after E1; result=8, found=1; busy high for exactly 1 cycle.
- Target A=0: guess sequence 8,4,2,1, then 0 in CONFIRM. done after E5; result=0, found=1.
- Target A=15: guess sequence 8,12,14,15. done after E4; result=15, found=1.
- Force cmp_code=00 at E2 (target 5): err=1, result=4, found=0, done after E2.
- Mid-search disturbances:
  - Change the target from 5 to 9 after E3: done after E5 with found=0.
  - Separately, assert rst at E2: all outputs 0 next cycle and no done pulse.
  - Separately, pulse start while busy: the pulse is ignored.
